// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch FSM states and PC constants.
// Imported by the fetch stage and the later pipelined core.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          WORD_BYTES       = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EXEC
    } fetch_state_e;

    // Word displacement of a branch: sign-extended immediate scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump, beq/bne branch targets, or fall-through.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] target_field,
    input  logic        jump,
    input  logic        branch_beq,
    input  logic        branch_bne,
    input  logic        zero,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        branch_taken;

    assign pc_plus4      = pc + 32'(WORD_BYTES);
    assign branch_target = pc_plus4 + branch_offset(target_field[15:0]);
    assign jump_target   = {pc_plus4[31:28], target_field, 2'b00};
    // Both branch conditions are independent; either one taking wins.
    assign branch_taken  = (branch_beq && zero) || (branch_bne && !zero);

    always_comb begin
        // NOTE: default assigned first so no path through this block infers a latch.
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: requests one instruction at pc, holds it for decode/execute,
// then advances pc via next_pc_calc when execute reports completion.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_unit_if.master      imem,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    input  logic              jump,
    input  logic              branch_beq,
    input  logic              branch_bne,
    input  logic              zero,
    input  logic              ex_done,
    output logic [31:0]       instret
);

    fetch_state_e state;
    logic         req_q;
    logic [31:0]  next_pc;

    next_pc_calc u_next_pc_calc (
        .pc           (pc),
        .target_field (instr[25:0]),
        .jump         (jump),
        .branch_beq   (branch_beq),
        .branch_bne   (branch_bne),
        .zero         (zero),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign opcode         = instr[31:26];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            req_q       <= 1'b0;
            instret     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                    req_q <= 1'b1;
                end
                S_REQ: begin
                    if (imem.imem_ack) begin
                        instr       <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        req_q       <= 1'b0;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Request the next word on the retire edge: no idle gap.
                    if (ex_done) begin
                        pc          <= next_pc;
                        instret     <= instret + 32'd1;
                        instr_valid <= 1'b0;
                        req_q       <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake timing, next-PC priority and wrap,
// reset behaviour; a second instance starts high in memory for jump targets.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump, branch_beq, branch_bne, zero, ex_done;
    logic [31:0] instr, pc, pc_plus4, instret;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] hi_instr, hi_pc, hi_pc_plus4, hi_instret;
    logic [5:0]  hi_opcode;
    logic        hi_instr_valid;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc      = 32'h0;
    logic [31:0] exp_instret = 32'h0;

    fetch_unit_if imem_bus ();
    fetch_unit_if hi_bus ();

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk (clk), .rst_n (rst_n), .imem (imem_bus),
        .instr (instr), .opcode (opcode), .instr_valid (instr_valid),
        .pc (pc), .pc_plus4 (pc_plus4),
        .jump (jump), .branch_beq (branch_beq), .branch_bne (branch_bne),
        .zero (zero), .ex_done (ex_done), .instret (instret)
    );

    fetch_unit #(.RESET_PC(32'h1000_0000)) dut_hi (
        .clk (clk), .rst_n (rst_n), .imem (hi_bus),
        .instr (hi_instr), .opcode (hi_opcode), .instr_valid (hi_instr_valid),
        .pc (hi_pc), .pc_plus4 (hi_pc_plus4),
        .jump (jump), .branch_beq (branch_beq), .branch_bne (branch_bne),
        .zero (zero), .ex_done (ex_done), .instret (hi_instret)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] br(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    // Fetch at exp_pc with `waits` cycles of ack delay; optionally drive ex_done meanwhile.
    task automatic fetch(input logic [31:0] word, input int waits, input logic stray_ex);
        int n = 0;
        while (!imem_bus.imem_req && n < 20) begin
            tick();
            n++;
        end
        if (!imem_bus.imem_req) check("req_timeout", 32'd0, 32'd1);
        for (int w = 0; w < waits; w++) begin
            check("req_held", 32'(imem_bus.imem_req), 32'd1);
            check("addr_held", imem_bus.imem_addr, exp_pc);
            ex_done = stray_ex;
            tick();
        end
        check("req_ack_cycle", 32'(imem_bus.imem_req), 32'd1);
        check("addr_ack_cycle", imem_bus.imem_addr, exp_pc);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = word;
        ex_done             = stray_ex;
        tick();
        imem_bus.imem_ack = 1'b0;
        ex_done           = 1'b0;
        check("fetched_valid", 32'(instr_valid), 32'd1);
        check("fetched_instr", instr, word);
        check("fetch_no_retire", instret, exp_instret);
    endtask

    task automatic retire(input logic j, input logic beq, input logic bne, input logic z,
                          input logic [31:0] next);
        jump = j; branch_beq = beq; branch_bne = bne; zero = z; ex_done = 1'b1;
        tick();
        jump = 1'b0; branch_beq = 1'b0; branch_bne = 1'b0; zero = 1'b0; ex_done = 1'b0;
        exp_pc = next;
        exp_instret++;
        check("retire_pc", pc, next);
        check("retire_addr", imem_bus.imem_addr, next);
        check("retire_req", 32'(imem_bus.imem_req), 32'd1);
        check("retire_valid", 32'(instr_valid), 32'd0);
        check("retire_instret", instret, exp_instret);
    endtask

    initial begin
        rst_n = 1'b0;
        jump = 1'b0; branch_beq = 1'b0; branch_bne = 1'b0; zero = 1'b0; ex_done = 1'b0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
        hi_bus.imem_ack   = 1'b0; hi_bus.imem_rdata   = 32'h0;
        tick();
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req", 32'(imem_bus.imem_req), 32'd0);
        check("rst_instret", instret, 32'h0);

        // First cycle after release is S_IDLE; stray ack and ex_done must be ignored.
        rst_n = 1'b1;
        check("idle_req", 32'(imem_bus.imem_req), 32'd0);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF; ex_done = 1'b1;
        tick();
        imem_bus.imem_ack = 1'b0; ex_done = 1'b0;
        check("first_req", 32'(imem_bus.imem_req), 32'd1);
        check("first_addr", imem_bus.imem_addr, 32'h0);
        check("idle_ack_ignored", instr, 32'h0);
        check("idle_ex_ignored", instret, 32'h0);

        fetch(32'h2008_0005, 0, 1'b0);
        check("addi_opcode", 32'(opcode), 32'(OP_ADDI));
        check("exec_req_low", 32'(imem_bus.imem_req), 32'd0);

        // Stray ack while executing.
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h1234_5678;
        tick();
        imem_bus.imem_ack = 1'b0;
        check("exec_ack_instr", instr, 32'h2008_0005);
        check("exec_ack_pc", pc, 32'h0);
        check("exec_ack_valid", 32'(instr_valid), 32'd1);

        retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
        check("retire_keeps_instr", instr, 32'h2008_0005);

        fetch(br(OP_BEQ, 16'h0002), 0, 1'b0);
        retire(1'b0, 1'b1, 1'b0, 1'b1, 32'h10);
        fetch(br(OP_BEQ, 16'hFFFC), 0, 1'b0);
        retire(1'b0, 1'b1, 1'b0, 1'b0, 32'h14);
        // Delayed ack with ex_done asserted through the wait and ack cycles.
        fetch(br(OP_BEQ, 16'hFFFE), 3, 1'b1);
        retire(1'b0, 1'b1, 1'b0, 1'b1, 32'h10);
        fetch(br(OP_BNE, 16'h0003), 0, 1'b0);
        retire(1'b0, 1'b0, 1'b1, 1'b0, 32'h20);
        fetch(br(OP_BEQ, 16'hFFFB), 0, 1'b0);
        retire(1'b0, 1'b1, 1'b0, 1'b1, 32'h10);
        fetch(br(OP_BEQ, 16'hFFFC), 0, 1'b0);
        retire(1'b0, 1'b1, 1'b0, 1'b1, 32'h4);
        fetch(br(OP_BNE, 16'h0003), 0, 1'b0);
        retire(1'b0, 1'b0, 1'b1, 1'b1, 32'h8);
        fetch(br(OP_BEQ, 16'h0001), 0, 1'b0);
        retire(1'b0, 1'b1, 1'b1, 1'b0, 32'h10);
        fetch(br(OP_BEQ, 16'hFFFA), 0, 1'b0);
        retire(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        fetch(32'h0000_0000, 0, 1'b0);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // High instance: jump target keeps pc_plus4[31:28]; jump beats beq.
        check("hi_addr", hi_bus.imem_addr, 32'h1000_0000);
        hi_bus.imem_ack = 1'b1; hi_bus.imem_rdata = {OP_J, 26'h0000100};
        tick();
        hi_bus.imem_ack = 1'b0;
        check("hi_valid", 32'(hi_instr_valid), 32'd1);
        jump = 1'b1; ex_done = 1'b1;
        tick();
        jump = 1'b0; ex_done = 1'b0;
        check("hi_jump_pc", hi_pc, 32'h1000_0400);
        hi_bus.imem_ack = 1'b1; hi_bus.imem_rdata = {OP_J, 26'h0000200};
        tick();
        hi_bus.imem_ack = 1'b0;
        jump = 1'b1; branch_beq = 1'b1; zero = 1'b1; ex_done = 1'b1;
        tick();
        jump = 1'b0; branch_beq = 1'b0; zero = 1'b0; ex_done = 1'b0;
        check("hi_jump_over_beq", hi_pc, 32'h1000_0800);
        check("hi_instret", hi_instret, 32'd2);
        check("main_req_idle_pc", pc, 32'h0);
        check("main_req_instret", instret, exp_instret);

        fetch(32'h0000_0000, 0, 1'b0);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
        // Asynchronous reset mid-request, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("midreq_rst_req", 32'(imem_bus.imem_req), 32'd0);
        check("midreq_rst_pc", pc, 32'h0);
        check("midreq_rst_instret", instret, 32'h0);
        check("midreq_rst_valid", 32'(instr_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rerelease_req", 32'(imem_bus.imem_req), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage directly upstream of the main decoder (control).
- Fetches one 32-bit instruction per step over a req/ack instruction-memory handshake and holds it in an instruction register.
- Presents opcode[5:0] and the full instruction to decode, then waits for execute completion.
- Computes the next PC from the decoder's jump/branch_beq/branch_bne outputs and the ALU zero flag; keeps a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request, level, held until ack
imem_addr  output  32  fetch byte address, equals pc, stable while imem_req=1
imem_ack  input  1  instruction memory accepts and returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
instr  output  32  instruction register
opcode  output  6  instr[31:26], feeds control
instr_valid  output  1  instr holds a fetched, not-yet-retired instruction
pc  output  32  address of instr
pc_plus4  output  32  pc + 4
jump  input  1  from control
branch_beq  input  1  from control
branch_bne  input  1  from control
zero  input  1  ALU zero flag
ex_done  input  1  execute/writeback complete for instr; sampled only when instr_valid=1
instret  output  32  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): state=S_IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, instret=0.
- instr=0 decodes as R-type sll $0 (a NOP). Downstream gates writes with instr_valid regardless.
- Reset is honoured at any point, including mid-request. An imem_ack arriving while imem_req=0 is ignored.
- FSM states: S_IDLE, S_REQ, S_EXEC.
- S_IDLE: lasts exactly one cycle after reset release, then goes to S_REQ. Gives the memory a clean first transaction.
- S_REQ:
  - Outputs: imem_req=1, imem_addr=pc.
  - On the edge where imem_ack=1: instr<=imem_rdata, instr_valid<=1, go to S_EXEC.
  - Otherwise stay in S_REQ with the address unchanged.
  - Zero-wait memory (ack in the first S_REQ cycle) gives 1-cycle fetch latency.
- S_EXEC:
  - Outputs: imem_req=0; instr, opcode and pc held stable.
  - On the edge where ex_done=1: pc<=next_pc, instret<=instret+1, instr_valid<=0, go to S_REQ.
  - instr keeps its old value until the next ack.
- ex_done is ignored outside S_EXEC. ex_done asserted in the same cycle as the ack does not retire the new instruction.
- next_pc is combinational and evaluated at the ex_done edge. Priority:
  1. jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}
  2. branch_beq=1 and zero=1: pc_plus4 + (sign_ext(instr[15:0]) << 2)
  3. branch_bne=1 and zero=0: pc_plus4 + (sign_ext(instr[15:0]) << 2)
  4. otherwise: pc_plus4
- If jump and a branch are asserted together, jump wins. branch_beq and branch_bne together: each term is evaluated independently and either taking condition takes the branch.
- Arithmetic is 32-bit modulo: pc=32'hFFFF_FFFC sequences to 32'h0000_0000. Backward branches wrap the same way. instret wraps 32'hFFFF_FFFF -> 0.
- Throughput: one instruction per (fetch latency + execute latency + 0) cycles. There is no idle cycle between retire and the next request.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_RTYPE 6'b000000, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_BEQ, OP_BNE, OP_J)
  - the fetch state enum (S_IDLE, S_REQ, S_EXEC)
  - RESET_PC default
  - WORD_BYTES=4
- One sub-module, next_pc_calc: purely combinational next-PC mux and adders, reused by the later pipelined core.

Test Plan:
- Reset then zero-wait ack, imem_rdata=32'h2008_0005 (addi) -> first req at pc=0 in the second cycle after release; instr_valid=1 one cycle later; opcode=6'b001000.
- ex_done with no branch or jump -> next imem_addr=32'h4; instret=1.
- beq at pc=32'h10, imm=16'hFFFC, zero=1 -> next pc=32'h4. Same with zero=0 -> 32'h14. bne with zero=0, imm=16'h0003 -> 32'h20.
- j at pc=32'h1000_0000, instr[25:0]=26'h0000100 -> next pc=32'h1000_0400. jump and branch_beq both high with zero=1 -> jump target taken.
- Ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles. Stray imem_ack and ex_done in S_IDLE/S_EXEC -> no state change.
- rst_n low mid-S_REQ -> outputs immediately at reset values. pc=32'hFFFF_FFFC plus sequential retire -> pc=0.
